dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory (256 x 8, combinational read, posedge write) between port 0 (CPU datapath) and port 1 (DMA/debug loader). It uses round-robin fairness with a bounded burst tenure, and drives the memory's writeEn, address and writeData. Memory readData returns through the arbiter to the current owner only. The arbiter sits between the requesters and the data memory; the memory is unchanged.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 256x8 data memory between the CPU
// datapath (port 0) and the DMA/debug loader (port 1), with bounded bursts.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic [7:0] rdata1,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_last;
    logic             w_last_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
        end
    end

    // r_last names the port that held the most recent tenure; the other wins ties
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_last_next = r_last;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (req0 && req1) begin
                    w_next = r_last ? OWN0 : OWN1;
                end else if (req0) begin
                    w_next = OWN0;
                end else if (req1) begin
                    w_next = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    w_next      = req1 ? OWN1 : IDLE;
                    w_cnt_next  = '0;
                    w_last_next = 1'b0;
                end else if (req1) begin
                    if (r_cnt == LP_CNT_MAX) begin
                        w_next      = OWN1;
                        w_cnt_next  = '0;
                        w_last_next = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    w_next      = req0 ? OWN0 : IDLE;
                    w_cnt_next  = '0;
                    w_last_next = 1'b1;
                end else if (req0) begin
                    if (r_cnt == LP_CNT_MAX) begin
                        w_next      = OWN0;
                        w_cnt_next  = '0;
                        w_last_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    assign gnt0 = (r_state == OWN0);
    assign gnt1 = (r_state == OWN1);

    // rst also gates writeEn so nothing commits while reset is held
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        unique case (r_state)
            OWN0: begin
                mem_we    = we0 & req0 & ~rst;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            OWN1: begin
                mem_we    = we1 & req1 & ~rst;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = 8'd0;
                mem_wdata = 8'd0;
            end
        endcase
    end

    assign rdata0 = gnt0 ? mem_rdata : 8'd0;
    assign rdata1 = gnt1 ? mem_rdata : 8'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table with hand-computed
// expectations plus an async-reset sequence, against a 256x8 memory model.
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, mem_we;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];
    bit         mem_init;

    int checks;
    int errors;

    dmem_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'd0;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        bit         rst_b;
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       g0, g1, mwe;
        logic [7:0] maddr, rd0, rd1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(bit rb,
        logic r0, logic w0, logic [7:0] a0, logic [7:0] d0,
        logic r1, logic w1, logic [7:0] a1, logic [7:0] d1,
        logic g0, logic g1, logic mwe, logic [7:0] ma,
        logic [7:0] rd0, logic [7:0] rd1);
        vec_t t;
        t.rst_b = rb;
        t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
        t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.mwe = mwe; t.maddr = ma;
        t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #2;
        chk("in_reset", {gnt0, gnt1, mem_we, mem_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("after_reset", {gnt0, gnt1, mem_we, mem_addr, rdata0, rdata1},
            32'h0);

        // port 0 single write, read-back, then drop req with we0 high
        vq.push_back(v(1, 1,1,101,8'hAA, 0,0,0,0,     0,0,0,0,0,0));
        vq.push_back(v(0, 1,1,101,8'hAA, 0,0,0,0,     1,0,1,101,0,0));
        vq.push_back(v(0, 1,0,101,0,     0,0,0,0,     1,0,0,101,8'hAA,0));
        vq.push_back(v(0, 0,1,102,8'hEE, 0,0,0,0,     1,0,0,102,0,0));
        // simultaneous requests after reset: port 0 first, no idle gap
        vq.push_back(v(1, 1,0,101,0,     1,0,101,0,   0,0,0,0,0,0));
        vq.push_back(v(0, 1,0,101,0,     1,0,101,0,   1,0,0,101,8'hAA,0));
        vq.push_back(v(0, 0,0,0,0,       1,0,101,0,   1,0,0,0,0,0));
        vq.push_back(v(0, 0,0,0,0,       1,0,101,0,   0,1,0,101,0,8'hAA));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     0,1,0,0,0,0));
        // port 1 alone for 10 cycles
        vq.push_back(v(0, 0,0,0,0,       1,0,101,0,   0,0,0,0,0,0));
        for (int i = 0; i < 10; i++)
            vq.push_back(v(0, 0,0,0,0,   1,0,101,0,   0,1,0,101,0,8'hAA));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     0,1,0,0,0,0));
        // port 0 burst, port 1 contends: 4 contended transfers then handover
        vq.push_back(v(0, 1,1,110,110,   0,0,0,0,     0,0,0,0,0,0));
        vq.push_back(v(0, 1,1,110,110,   1,0,110,0,   1,0,1,110,0,0));
        vq.push_back(v(0, 1,1,111,111,   1,0,110,0,   1,0,1,111,0,0));
        vq.push_back(v(0, 1,1,112,112,   1,0,110,0,   1,0,1,112,0,0));
        vq.push_back(v(0, 1,1,113,113,   1,0,110,0,   1,0,1,113,0,0));
        vq.push_back(v(0, 1,1,114,114,   1,0,110,0,   0,1,0,110,0,110));
        vq.push_back(v(0, 1,1,114,114,   1,0,111,0,   0,1,0,111,0,111));
        vq.push_back(v(0, 1,1,114,114,   0,0,0,0,     0,1,0,0,0,0));
        vq.push_back(v(0, 1,1,114,114,   0,0,0,0,     1,0,1,114,0,0));
        vq.push_back(v(0, 1,1,115,115,   0,0,0,0,     1,0,1,115,0,0));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     1,0,0,0,0,0));
        // tie with last==0 goes to port 1; verify burst data
        vq.push_back(v(0, 1,0,0,0,       1,0,113,0,   0,0,0,0,0,0));
        vq.push_back(v(0, 1,0,0,0,       1,0,113,0,   0,1,0,113,0,113));
        vq.push_back(v(0, 1,0,0,0,       1,0,114,0,   0,1,0,114,0,114));
        vq.push_back(v(0, 1,0,0,0,       0,0,0,0,     0,1,0,0,0,0));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     1,0,0,0,0,0));
        // drop req0 with we0 high while port 1 waits: no write, go OWN1
        vq.push_back(v(0, 1,0,120,0,     0,0,0,0,     0,0,0,0,0,0));
        vq.push_back(v(0, 1,0,120,0,     0,0,0,0,     1,0,0,120,0,0));
        vq.push_back(v(0, 0,1,120,8'hEE, 1,0,120,0,   1,0,0,120,0,0));
        vq.push_back(v(0, 0,0,0,0,       1,0,120,0,   0,1,0,120,0,0));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     0,1,0,0,0,0));
        vq.push_back(v(0, 0,0,0,0,       0,0,0,0,     0,0,0,0,0,0));

        foreach (vq[i]) begin
            if (vq[i].rst_b) do_reset();
            @(negedge clk);
            req0 = vq[i].r0; we0 = vq[i].w0;
            addr0 = vq[i].a0; wdata0 = vq[i].d0;
            req1 = vq[i].r1; we1 = vq[i].w1;
            addr1 = vq[i].a1; wdata1 = vq[i].d1;
            #2;
            checks++;
            if ({gnt0, gnt1, mem_we, mem_addr, rdata0, rdata1} !==
                {vq[i].g0, vq[i].g1, vq[i].mwe, vq[i].maddr,
                 vq[i].rd0, vq[i].rd1}) begin
                errors++;
                $display("FAIL vec%0d: got g0=%b g1=%b we=%b a=%0d rd0=%h rd1=%h, expected g0=%b g1=%b we=%b a=%0d rd0=%h rd1=%h",
                    i, gnt0, gnt1, mem_we, mem_addr, rdata0, rdata1,
                    vq[i].g0, vq[i].g1, vq[i].mwe, vq[i].maddr,
                    vq[i].rd0, vq[i].rd1);
            end
        end

        chk("mem102_untouched", {24'h0, mem[102]}, 32'h0);
        chk("mem120_untouched", {24'h0, mem[120]}, 32'h0);
        chk("mem113_written", {24'h0, mem[113]}, 32'd113);

        // async reset in the middle of a port 0 write
        do_reset();
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'd105; wdata0 = 8'hFF;
        @(negedge clk);
        #2;
        chk("t5_pre", {gnt0, gnt1, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b0, 1'b1, 8'd105, 8'hFF});
        rst = 1'b1;
        #1;
        chk("t5_async", {gnt0, gnt1, mem_we, mem_addr}, 32'h0);
        @(negedge clk);
        chk("t5_nowrite", {31'h0, mem[105] == 8'hFF}, 32'h0);
        rst = 1'b0;
        idle_inputs();
        #2;
        chk("t5_idle", {gnt0, gnt1, mem_we}, 32'h0);
        @(negedge clk);
        req1 = 1; addr1 = 8'd110;
        #2;
        chk("t5_still_idle", {gnt0, gnt1}, 32'h0);
        @(negedge clk);
        #2;
        chk("t5_regrant", {gnt0, gnt1, rdata1}, {1'b0, 1'b1, 8'd110});
        idle_inputs();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
